// File: rtl/pokey_audf_pkg.sv
// pokey_audf_pkg
// Shared constants for the POKEY audio-frequency sequencer:
//   - register write addresses as seen on wr_addr
//   - AUDCTL bit positions used by the sequencer
//   - sequencer FSM state encoding
//   - address validity helper (addresses 6-7 are not registers)
package pokey_audf_pkg;

   localparam logic [2:0] ADDR_AUDF1  = 3'd0;
   localparam logic [2:0] ADDR_AUDF2  = 3'd1;
   localparam logic [2:0] ADDR_AUDF3  = 3'd2;
   localparam logic [2:0] ADDR_AUDF4  = 3'd3;
   localparam logic [2:0] ADDR_AUDCTL = 3'd4;
   localparam logic [2:0] ADDR_STIMER = 3'd5;

   localparam int AC_CH1_179 = 6;   // ch0 clocked on every enp
   localparam int AC_CH3_179 = 5;   // ch2 clocked on every enp
   localparam int AC_JOIN12  = 4;   // ch0+ch1 form one 16-bit divider
   localparam int AC_JOIN34  = 3;   // ch2+ch3 form one 16-bit divider

   typedef enum logic [2:0] {
      ST_INIT0,
      ST_INIT1,
      ST_INIT2,
      ST_INIT3,
      ST_RUN
   } seq_state_t;

   function automatic logic addr_valid(input logic [2:0] addr);
      return (addr <= ADDR_STIMER);
   endfunction

endpackage

// File: rtl/pokey_audf_chan.sv
// pokey_audf_chan
// One audio channel slice: the channel counter, its tick selection, the
// zero-reduction of the bank compare outputs and the D-bus mux.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   enp, tick_base  phase enable and base-rate tick
//   fast            1 = tick on every enp instead of tick_base
//   inc, clr        counter advance / clear (clr wins)
//   ld_sel, ld_data drive ld_data on d instead of the counter
//   cmp             bank compare outputs (Q^D)
//   tick            this channel's tick for the current cycle
//   zero            all compare bits are zero (bank value equals d)
//   wrap            counter is at its maximum (carry into a joined high half)
//   d               D bus into the bank
module pokey_audf_chan #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enp,
   input  logic             tick_base,
   input  logic             fast,
   input  logic             inc,
   input  logic             clr,
   input  logic             ld_sel,
   input  logic [CNT_W-1:0] ld_data,
   input  logic [CNT_W-1:0] cmp,
   output logic             tick,
   output logic             zero,
   output logic             wrap,
   output logic [CNT_W-1:0] d
);

   logic [CNT_W-1:0] ctr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ctr <= '0;
      else if (clr)
         ctr <= '0;
      else if (inc)
         ctr <= ctr + 1'b1;
   end

   assign tick = enp & (fast | tick_base);
   assign zero = (cmp == '0);
   assign wrap = &ctr;
   assign d    = ld_sel ? ld_data : ctr;

endmodule

// File: rtl/pokey_audf_seq.sv
// pokey_audf_seq
// Sequencer for the four AUDF compare banks. Zeroes every bank after reset,
// turns CPU writes into bank load strobes and counter resets, and decodes
// the bank compare outputs into per-channel divide-by-(N+1) pulses,
// including the 16-bit joined pairs.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   enp          phase enable; all state changes and ld strobes need enp=1
//   tick_base    base-rate tick, sampled when enp=1
//   wr_en        CPU write strobe (wr_addr: 0-3 AUDF1-4, 4 AUDCTL, 5 STIMER)
//   wr_addr      register address
//   wr_data      register data
//   d            per-bank D bus, channel i on [CNT_W*i +: CNT_W]
//   ld           per-bank load strobe
//   cmp          per-bank compare outputs (Q^D)
//   pulse        per-channel one-clk divider pulse (registered)
//   audctl       current AUDCTL value
module pokey_audf_seq
   import pokey_audf_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enp,
   input  logic               tick_base,
   input  logic               wr_en,
   input  logic [2:0]         wr_addr,
   input  logic [7:0]         wr_data,
   output logic [4*CNT_W-1:0] d,
   output logic [3:0]         ld,
   input  logic [4*CNT_W-1:0] cmp,
   output logic [3:0]         pulse,
   output logic [7:0]         audctl
);

   seq_state_t       state;
   logic             pend_v;
   logic [2:0]       pend_addr;
   logic [7:0]       pend_data;

   logic             run_en;
   logic             apply;
   logic             ctr_rst;
   logic [3:0]       ld_ch;
   logic [3:0]       init_ld;
   logic [CNT_W-1:0] ld_data;
   logic [3:0]       tick;
   logic [3:0]       zero;
   logic [3:0]       wrap;
   logic [3:0]       inc;
   logic [3:0]       clr;
   logic [3:0]       hit;
   logic [3:0]       pulse_nxt;
   logic             unused_wrap;

   assign run_en  = enp & (state == ST_RUN);
   assign apply   = run_en & pend_v;
   assign ctr_rst = apply & ((pend_addr == ADDR_AUDCTL) | (pend_addr == ADDR_STIMER));
   assign ld_data = (state == ST_RUN) ? CNT_W'(pend_data) : '0;
   assign ld      = (enp ? init_ld : 4'b0000) | ld_ch;

   // High halves never carry further, so their wrap flags are not needed.
   assign unused_wrap = wrap[1] ^ wrap[3];

   always_comb begin
      init_ld = 4'b0000;
      case (state)
         ST_INIT0: init_ld = 4'b0001;
         ST_INIT1: init_ld = 4'b0010;
         ST_INIT2: init_ld = 4'b0100;
         ST_INIT3: init_ld = 4'b1000;
         default:  init_ld = 4'b0000;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         ld_ch[i] = apply & (pend_addr == 3'(i));
   end

   // Per-pair match decode. A channel being loaded this cycle sees its new
   // value on d rather than its counter, so its compare result is ignored.
   always_comb begin
      inc = 4'b0000;
      clr = 4'b0000;
      hit = 4'b0000;
      for (int p = 0; p < 2; p++) begin
         int  lo;
         int  hi;
         logic joined;
         logic m_lo;
         logic m_hi;
         logic m_pair;
         lo     = 2 * p;
         hi     = 2 * p + 1;
         joined = (p == 0) ? audctl[AC_JOIN12] : audctl[AC_JOIN34];
         m_lo   = zero[lo] & ~ld_ch[lo];
         m_hi   = zero[hi] & ~ld_ch[hi];
         m_pair = m_lo & m_hi;
         if (joined) begin
            // 16-bit count on the low channel's tick; high half advances on carry.
            hit[hi] = run_en & tick[lo] & m_pair;
            inc[lo] = run_en & tick[lo] & ~m_pair;
            inc[hi] = run_en & tick[lo] & ~m_pair & wrap[lo];
            clr[lo] = hit[hi];
            clr[hi] = hit[hi];
         end else begin
            hit[lo] = run_en & tick[lo] & m_lo;
            hit[hi] = run_en & tick[hi] & m_hi;
            inc[lo] = run_en & tick[lo] & ~m_lo;
            inc[hi] = run_en & tick[hi] & ~m_hi;
            clr[lo] = hit[lo];
            clr[hi] = hit[hi];
         end
      end
      clr       = clr | {4{ctr_rst}};
      pulse_nxt = ctr_rst ? 4'b0000 : hit;
   end

   for (genvar i = 0; i < 4; i++) begin : g_chan
      pokey_audf_chan #(.CNT_W(CNT_W)) u_chan (
         .clk       (clk),
         .reset     (reset),
         .enp       (enp),
         .tick_base (tick_base),
         .fast      ((i == 0) ? audctl[AC_CH1_179] :
                     (i == 2) ? audctl[AC_CH3_179] : 1'b0),
         .inc       (inc[i]),
         .clr       (clr[i]),
         .ld_sel    (ld[i]),
         .ld_data   (ld_data),
         .cmp       (cmp[i*CNT_W +: CNT_W]),
         .tick      (tick[i]),
         .zero      (zero[i]),
         .wrap      (wrap[i]),
         .d         (d[i*CNT_W +: CNT_W])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_INIT0;
         pend_v    <= 1'b0;
         pend_addr <= 3'd0;
         pend_data <= 8'h00;
         audctl    <= 8'h00;
         pulse     <= 4'b0000;
      end else begin
         pulse <= pulse_nxt;

         if (enp) begin
            case (state)
               ST_INIT0: state <= ST_INIT1;
               ST_INIT1: state <= ST_INIT2;
               ST_INIT2: state <= ST_INIT3;
               ST_INIT3: state <= ST_RUN;
               default:  state <= ST_RUN;
            endcase
         end

         // A new write always takes the slot, even while the old entry applies.
         if (wr_en && addr_valid(wr_addr)) begin
            pend_v    <= 1'b1;
            pend_addr <= wr_addr;
            pend_data <= wr_data;
         end else if (apply) begin
            pend_v <= 1'b0;
         end

         if (apply && (pend_addr == ADDR_AUDCTL))
            audctl <= pend_data;
      end
   end

endmodule

// File: tb/tb_pokey_audf_seq.sv
module tb_pokey_audf_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        enp;
   logic        tick_base;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [31:0] d;
   logic [3:0]  ld;
   logic [31:0] cmp;
   logic [3:0]  pulse;
   logic [7:0]  audctl;

   always #5 clk = ~clk;

   pokey_audf_seq #(.CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .enp       (enp),
      .tick_base (tick_base),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .d         (d),
      .ld        (ld),
      .cmp       (cmp),
      .pulse     (pulse),
      .audctl    (audctl)
   );

   // Compare-cell banks: each holds the last value loaded and outputs Q^D.
   logic [7:0] bank [4] = '{default: 8'h00};
   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (ld[i]) bank[i] <= d[8*i +: 8];
   assign cmp = {bank[3], bank[2], bank[1], bank[0]} ^ d;

   // Reference model: dividers as integer counts against programmed values.
   int         st;
   bit         pv;
   bit [2:0]   pa;
   bit [7:0]   pd;
   bit [7:0]   ac;
   int         cnt [4];
   int         nv  [4];
   int         vecs;
   int         errs;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      st = 0; pv = 0; pa = 0; pd = 0; ac = 0;
      for (int i = 0; i < 4; i++) begin cnt[i] = 0; nv[i] = 0; end
   endtask

   task automatic step(input bit en, input bit tb, input bit we,
                       input bit [2:0] wa, input bit [7:0] wdt);
      bit [3:0]  eld, np, lm, tk;
      bit [31:0] ed;
      bit        rs, applied;
      int        v, n, lo, hi;
      @(negedge clk);
      enp = en; tick_base = tb; wr_en = we; wr_addr = wa; wr_data = wdt;
      eld = 0; np = 0; lm = 0; rs = 0; applied = 0;
      ed = {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
      if (st < 4) begin
         if (en) begin
            eld[st] = 1'b1;
            ed[8*st +: 8] = 8'h00;
            st++;
         end
      end else if (en) begin
         if (pv) begin
            applied = 1;
            if (pa < 4) begin
               lm[pa] = 1'b1;
               eld[pa] = 1'b1;
               ed[8*pa +: 8] = pd;
            end else rs = 1;
         end
         tk = {tb, ac[5] | tb, tb, ac[6] | tb};
         for (int p = 0; p < 2; p++) begin
            lo = 2 * p; hi = lo + 1;
            if (ac[4-p]) begin
               if (tk[lo]) begin
                  v = cnt[hi] * 256 + cnt[lo];
                  n = nv[hi] * 256 + nv[lo];
                  if (v == n && !lm[lo] && !lm[hi]) begin np[hi] = 1'b1; v = 0; end
                  else v = (v + 1) % 65536;
                  cnt[lo] = v % 256; cnt[hi] = v / 256;
               end
            end else begin
               for (int c = lo; c <= hi; c++)
                  if (tk[c]) begin
                     if (cnt[c] == nv[c] && !lm[c]) begin np[c] = 1'b1; cnt[c] = 0; end
                     else cnt[c] = (cnt[c] + 1) % 256;
                  end
            end
         end
         if (rs) begin
            np = 0;
            for (int i = 0; i < 4; i++) cnt[i] = 0;
            if (pa == 3'd4) ac = pd;
         end
         if (lm != 0) nv[pa] = pd;
      end
      if (we && wa < 6) begin pv = 1; pa = wa; pd = wdt; end
      else if (applied) pv = 0;
      #1;
      chk("ld", {28'd0, ld}, {28'd0, eld});
      chk("d", d, ed);
      @(posedge clk);
      #1;
      chk("pulse", {28'd0, pulse}, {28'd0, np});
      chk("audctl", {24'd0, audctl}, {24'd0, ac});
   endtask

   task automatic rand_step();
      bit [2:0] wa;
      bit [7:0] wdt;
      wa  = 3'($urandom_range(0, 7));
      wdt = (wa == 3'd4) ? (8'($urandom_range(0, 255)) & 8'h78) : 8'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, wa, wdt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; enp = 1'b0; wr_en = 1'b0;
      #1;
      chk("rst_pulse", {28'd0, pulse}, 32'd0);
      chk("rst_ld", {28'd0, ld}, 32'd0);
      chk("rst_d", d, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b1; enp = 1'b0; tick_base = 1'b0;
      wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
      vecs = 0; errs = 0;
      model_reset();
      do_reset();

      // INIT sequence with enp held high, then into RUN
      repeat (6) step(1, 0, 0, 0, 0);

      // AUDF1 = 3, tick every enp
      step(1, 1, 1, 0, 3);
      repeat (40) step(1, 1, 0, 0, 0);

      // ch0+ch1 joined, N = 0x0101
      step(1, 1, 1, 4, 8'h10);
      step(1, 1, 1, 0, 1);
      step(1, 1, 1, 1, 1);
      repeat (600) step(1, 1, 0, 0, 0);

      // ch0 on the fast clock, AUDF1 = 9, no base ticks
      step(1, 0, 1, 4, 8'h40);
      step(1, 0, 1, 0, 9);
      repeat (40) step(1, 0, 0, 0, 0);

      // back-to-back AUDF3 writes with no enp between
      step(1, 1, 1, 4, 8'h00);
      step(0, 0, 1, 2, 5);
      step(0, 0, 1, 2, 7);
      repeat (40) step(1, 1, 0, 0, 0);

      // STIMER mid-count, then invalid addresses
      repeat (3) step(1, 1, 0, 0, 0);
      step(1, 1, 1, 5, 0);
      repeat (20) step(1, 1, 0, 0, 0);
      step(1, 1, 1, 6, 8'h55);
      step(1, 1, 1, 7, 8'hAA);
      repeat (10) step(1, 1, 0, 0, 0);

      repeat (3000) rand_step();

      // reset mid-count, writes arriving during INIT
      do_reset();
      step(1, 0, 1, 3, 2);
      repeat (8) step($urandom_range(0, 1) == 1, 1, 0, 0, 0);
      repeat (2000) rand_step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pokey_audf_seq.md
# pokey_audf_seq

Sequencer for the four POKEY audio-frequency compare banks, each eight `cell4` compare cells. The block does three things:
- Owns the four 8-bit channel counters and drives the shared `D` bus into each bank.
- Turns CPU writes to AUDF1–4, AUDCTL and STIMER into `Ld` strobes and counter resets.
- Decodes the banks' compare outputs into per-channel divide-by-(N+1) pulses, including 16-bit joined mode.

It sits between the register decode and the compare-cell banks, and feeds the poly/output stage.

## Interface
Parameters:
- `CNT_W`, 8: counter and compare width per channel.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `enp`  in  1  phase enable. All state updates and `Ld` strobes occur only when `enp`=1.
- `tick_base`  in  1  base-rate tick (64 kHz/15 kHz, selected upstream). Sampled only when `enp`=1.
- `wr_en`  in  1  CPU write strobe, one `clk`.
- `wr_addr`  in  3  0–3 = AUDF1–4, 4 = AUDCTL, 5 = STIMER, 6–7 ignored.
- `wr_data`  in  8  write data.
- `d`  out  4*CNT_W  per-bank `D` bus, channel i on bits [8i+7:8i].
- `ld`  out  4  per-bank load strobe.
- `cmp`  in  4*CNT_W  per-bank `C` outputs (Q^D).
- `pulse`  out  4  per-channel divider output, one-`clk` pulse.
- `audctl`  out  8  current AUDCTL value.

## Operation
- **FSM:** INIT0 → INIT1 → INIT2 → INIT3 → RUN. Each step advances on one `enp` cycle.
  - INITi: `ld[i]`=1 with `d` for channel i = 0x00, so after reset every bank holds 0.
  - During INIT: counters hold, `pulse`=0, and CPU writes collect in the pending slot.
- **Pending slot:**
  - `wr_en` with a valid address captures (addr, data) on any `clk`. The last write before the next RUN `enp` cycle wins.
  - Addresses 6–7 are dropped.
  - The pending write is applied on the first RUN `enp` cycle, then the slot clears.
- **AUDFi apply:** `ld[i]`=1 and `d`[i] = data for that cycle. The match for channel i is suppressed that cycle; its counter still advances normally.
- **AUDCTL apply:** register updated, and all four counters reset to 0 at the end of the cycle.
- **STIMER apply:** all counters reset to 0.
- **Counter ticks:**
  - ch0 ticks on every `enp` if AUDCTL[6], else on `tick_base`.
  - ch2 ticks on every `enp` if AUDCTL[5], else on `tick_base`.
  - ch1 and ch3 tick on `tick_base`.
- **Unjoined match:**
  - Outside load cycles, `d`[i] = ctr[i]. A match on channel i is `cmp`[i] == 0.
  - Tick with match: ctr := 0 and `pulse[i]` is asserted. Tick without match: ctr := ctr+1, wrapping 255 → 0.
  - The period is N+1 ticks.
- **Joined pairs:**
  - AUDCTL[4] joins ch0+ch1; AUDCTL[3] joins ch2+ch3.
  - The pair counts as a 16-bit counter {ctr[hi], ctr[lo]} on the low channel's tick.
  - The match requires both `cmp` fields to be zero. On a match both counters clear and only `pulse[hi]` fires; `pulse[lo]`=0.
  - A load to either half suppresses the pair match that cycle.
- **Pulse pass-through:** when `enp`=0 or no tick, counters hold and no pulse is generated.

## Timing
- **Reset values:**
  - FSM = INIT0, ctr = 0, audctl = 0x00, pending = empty, `pulse` = 0.
  - `ld` reflects INIT0, i.e. `ld[0]` is high at the first `enp`.
- **Combinational paths:** `d` and `ld` are functions of the FSM, pending and ctr. `cmp` is sampled in the same cycle.
- **Pulse latency:** a match in `enp` cycle k gives `pulse` high during cycle k+1 for exactly one `clk`, registered.
- **Write latency:** a write on `clk` t is applied on the first RUN `enp` cycle at or after t+1.
- **Reset mid-operation:** returns to INIT0 and the pending write is lost. Cells are re-zeroed by the INIT sequence.
- **Simultaneous events:**
  - `wr_en` in the same `clk` as a pending apply: the old entry applies and the new one becomes pending.
  - A counter reset (AUDCTL/STIMER) overrides a tick-match pulse in the same cycle, so no pulse is emitted.

## Structure
- `pokey_audf_pkg`:
  - Address constants `ADDR_AUDF1..4`, `ADDR_AUDCTL`, `ADDR_STIMER`.
  - AUDCTL bit indices `AC_CH1_179`, `AC_CH3_179`, `AC_JOIN12`, `AC_JOIN34`.
  - FSM state enum.
- Sub-module `pokey_audf_chan`: one counter, its tick mux input, the `cmp` reduction, and the `D` mux. Instantiated four times.
- The top level holds the FSM, the pending slot, AUDCTL and the join logic.
- The `cell4` banks are instantiated in the bench/top, not inside this block.

## Test plan
- **Reset and INIT:** release reset with `enp` always 1 → `ld` = 0001, 0010, 0100, 1000 on consecutive cycles with `d`=0, then RUN. No pulses.
- **AUDF1 divider:** write AUDF1=3, `tick_base` every `enp` → `pulse[0]` every 4 ticks; ch1–3 with AUDF=0 pulse on every tick.
- **Joined ch0+ch1:** AUDCTL=0x10, AUDF1=0x01, AUDF2=0x01 → `pulse[1]` every 258 ticks, `pulse[0]` never.
- **Fast clock:** AUDCTL=0x40, AUDF1=9, `tick_base`=0 → `pulse[0]` every 10 `enp` cycles.
- **Back-to-back writes and STIMER:**
  - Two AUDF3 writes (5 then 7) before one `enp` → only 7 is loaded; `pulse[2]` period is 8.
  - STIMER mid-count → all ctr = 0 and no pulse that cycle.
- **Reset mid-count:** assert `reset` mid-count → `pulse`=0 immediately and the INIT sequence repeats.
